lsu_bus_ctrl: RTL
=================

Name: lsu_bus_ctrl

Overview:
Load/store unit bus controller in the EX/MEM boundary of the 5-stage core. It turns the EX-stage memory request into a single-outstanding bus transaction, formats byte/half/word data, and drives `busy` into the hazard detection unit. `busy` holds the whole pipeline until the transaction completes, so the request inputs stay stable for the whole transaction.

Parameters:
TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before a transaction is aborted (used only with LSU_TIMEOUT_EN); counter 8 bits wide.

Ports:
clk  in  1  core clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_rmem  in  1  EX instruction is a load
req_wmem  in  1  EX instruction is a store; never both with req_rmem
req_addr  in  32  effective address
req_wdata  in  32  store data, rs2, unaligned in the low bits
req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
busy  out  1  to hazard detection; pipeline hold
misalign  out  1  request misaligned, no bus access made
rdata  out  32  formatted load result
rdata_valid  out  1  one-cycle completion strobe for a load
bus_err  out  1  transaction aborted (timeout)
bus_req  out  1  bus request, held until bus_gnt
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_gnt  in  1  slave accepts request this cycle
bus_rvalid  in  1  response/ack; at least 1 cycle after bus_gnt
bus_rdata  in  32  read data, valid with bus_rvalid

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE. All outputs reset to 0.
- IDLE
  - An aligned request (rmem|wmem) latches addr, size, wdata and we. The FSM goes to REQ.
  - busy=1 combinationally in that same cycle.
- REQ
  - bus_req=1, bus_* driven from the latched values.
  - On bus_gnt the FSM goes to WAIT.
- WAIT
  - bus_req=0.
  - On bus_rvalid the FSM captures bus_rdata and goes to DONE.
- DONE
  - busy=0. rdata_valid=1 for a load, 0 for a store. The FSM goes to IDLE next cycle.
  - Request inputs are ignored in DONE: they still belong to the completed instruction, and the pipeline advances at the end of this cycle.
- busy
  - busy = (IDLE & aligned req) | REQ | WAIT.
  - Minimum transaction: busy high for 3 cycles, then DONE.
- Misalignment
  - Misaligned means H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
  - misalign = IDLE & req & misaligned, combinational level.
  - No bus access is made, busy stays 0, rdata_valid=0, and the FSM stays in IDLE.
- Stores
  - SB: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = 0011<<{addr[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111, wdata passed through.
- Loads
  - bus_be = 1111 for all loads.
  - Shift: data = bus_rdata >> (8*addr[1:0]).
  - B and H are sign-extended from bit 7 / bit 15; BU and HU are zero-extended; W passes through.
- rdata is a register: it holds its value outside DONE and is updated only on load completion.
- bus_gnt and bus_rvalid outside REQ and WAIT respectively are ignored.
- Reset mid-transaction: FSM returns to IDLE at the edge, and bus_req=0 from the next cycle. A late bus_rvalid is ignored.
- Only one transaction is outstanding at a time; there is no pipelining of bus requests.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to DONE with bus_err=1 (one cycle) and rdata_valid=0. rdata is unchanged, and bus_req drops.
- Undefined: no counter, bus_err tied 0, and the FSM may wait indefinitely.

Test Plan:
- LW addr 0x100, gnt in REQ cycle 1, rvalid=1 rdata 0xDEADBEEF in WAIT cycle 2 -> busy 1,1,1,0; DONE: rdata=0xDEADBEEF, rdata_valid=1, bus_be=1111, bus_addr=0x100.
- LB addr 0x103, bus_rdata 0x80FFFFFF -> rdata 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SH addr 0x102, wdata 0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD; rvalid ack -> DONE, rdata_valid=0.
- LW addr 0x101 -> misalign=1, busy=0, bus_req=0 for all cycles, FSM remains IDLE.
- bus_gnt held low 5 cycles -> bus_req/busy stay 1 with stable bus_addr; rst=1 in WAIT -> next cycle busy=0, a later bus_rvalid causes no rdata_valid.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no gnt -> bus_err pulses after 4 REQ cycles, busy falls, rdata_valid=0.

Source files
------------

// File: rtl/lsu_bus_ctrl_if.sv
// Bus-side handshake of the LSU bus controller: a single-outstanding
// request/grant/response channel with word-aligned address and byte enables.
interface lsu_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  // LSU side: issues requests, consumes grant and response
  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata
  );

  // Memory side: accepts requests, returns grant and response
  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// LSU bus controller at the EX/MEM boundary. Turns one EX-stage load/store
// into a single bus transaction (IDLE -> REQ -> WAIT -> DONE), formats store
// lanes and load results, and holds the pipeline via busy while in flight.
// Optional feature macro: LSU_TIMEOUT_EN (abort after TIMEOUT_CYCLES cycles
// in REQ+WAIT with a one-cycle bus_err strobe). Default build has no timeout.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_rmem,
  input  logic           req_wmem,
  input  logic [31:0]    req_addr,
  input  logic [31:0]    req_wdata,
  input  logic [2:0]     req_size,
  output logic           busy,
  output logic           misalign,
  output logic [31:0]    rdata,
  output logic           rdata_valid,
  output logic           bus_err,
  lsu_bus_ctrl_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // The timeout counter is 8 bits wide, so the limit must fit in 1..255.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lsu_bus_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0]  state_q, state_d;
  logic        req_any;
  logic        misaligned;
  logic        accept;
  logic        in_flight;
  logic        timeout_hit;
  logic        err_q, err_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_shifted;
  logic [31:0] ld_data;

  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  assign req_any   = req_rmem | req_wmem;
  assign accept    = (state_q == StIdle) & req_any & ~misaligned;
  assign in_flight = (state_q == StReq) | (state_q == StWait);

  // Alignment rule depends only on access width (funct3[1:0]).
  always_comb begin
    misaligned = 1'b0;
    case (req_size[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Store lane placement: replicate the datum across the word, enable its lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_size[1:0])
      2'b00: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {req_addr[1], 1'b0};
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  // Load result: bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    ld_shifted = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_data = {24'h000000, ld_shifted[7:0]};
      3'b101:  ld_data = {16'h0000, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc;

  // Extra bit keeps the compare exact even at the 255 limit.
  assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
  assign timeout_hit = in_flight & (cnt_inc >= 9'(TIMEOUT_CYCLES));

  // Cycle counter: cleared on entry to REQ, counts every REQ/WAIT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = 8'h00;
    end else if (in_flight) begin
      cnt_d = cnt_inc[7:0];
    end
  end

  // Timeout counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Transaction sequencing; a real grant/response wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.bus_gnt) begin
          state_d = StWait;
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StWait: begin
        if (bus.bus_rvalid) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        // Request inputs still belong to the finished instruction here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and abort flag (flag lives only for the DONE cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Request capture on acceptance and load-data capture on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 32'h0;
      size_q  <= 3'b000;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        we_q    <= req_wmem;
        be_q    <= req_wmem ? st_be : 4'b1111;
        wdata_q <= req_wmem ? st_wdata : 32'h0;
      end
      if ((state_q == StWait) && bus.bus_rvalid && !we_q) begin
        rdata_q <= ld_data;
      end
    end
  end

  assign busy        = accept | in_flight;
  assign misalign    = (state_q == StIdle) & req_any & misaligned;
  assign rdata       = rdata_q;
  assign rdata_valid = (state_q == StDone) & ~we_q & ~err_q;

`ifdef LSU_TIMEOUT_EN
  assign bus_err = (state_q == StDone) & err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign bus.bus_req   = (state_q == StReq);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule
